// File: rtl/hashcore_pkg.sv
// Shared types and default parameters for the multi-core nonce dispatcher.
package hashcore_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    localparam int DEF_NCORES   = 2;
    localparam int DEF_PERIOD   = 16;
    localparam int DEF_PREFIX_W = 5;
    localparam int DEF_GN_DEPTH = 4;

endpackage

// File: rtl/gn_fifo.sv
// Golden-nonce FIFO: write is visible at the head one cycle after push; pop on vld_o & rdy_i.
// A push into a full FIFO without a same-cycle pop is dropped and sets the sticky overflow flag.
module gn_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         ovf_clr_i,
    input  logic         rdy_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o,
    output logic         ovf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, rd_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         ovf_q;
    logic         empty, full, do_pop, do_push;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = !empty && rdy_i;
    assign do_push = push_i && (!full || do_pop);

    assign vld_o = !empty;
    assign dat_o = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign ovf_o = ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (push_i && full && !do_pop) ovf_q <= 1'b1;
            else if (ovf_clr_i)            ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/hashcore_mc.sv
// Nonce dispatcher: staggers one start per core each PERIOD-clock round and queues golden nonces.
// Starts are combinational on the RUN phase; matches are sampled the cycle after each start.
module hashcore_mc
    import hashcore_pkg::*;
#(
    parameter int NCORES   = DEF_NCORES,
    parameter int PERIOD   = DEF_PERIOD,
    parameter int PREFIX_W = DEF_PREFIX_W,
    parameter int GN_DEPTH = DEF_GN_DEPTH
) (
    input  logic                   hash_clk,
    input  logic                   rst_n,
    input  logic                   shift,
    input  logic [31:0]            initnonce,
    input  logic [PREFIX_W-1:0]    nonce_msb,
    output logic [NCORES-1:0]      core_start,
    output logic [32*NCORES-1:0]   core_nonce,
    input  logic [NCORES-1:0]      core_match,
    output logic [31:0]            gn_nonce,
    output logic                   gn_valid,
    input  logic                   gn_ready,
    output logic                   gn_strobe,
    output logic                   gn_overflow,
    output logic                   wrapped,
    output logic [31:0]            nonce_out
);
    localparam int BW = 32 - PREFIX_W;
    localparam int PW = $clog2(PERIOD);

    state_e                   state_q, state_d;
    logic [PW-1:0]            phase_q, phase_d;
    logic                     gap_q, gap_d;
    logic [BW-1:0]            base_q, base_d;
    logic [BW:0]              base_sum;
    logic                     wrapped_q, wrapped_d;
    logic                     load;
    logic [31:0]              nonce_out_q;
    logic [NCORES-1:0][31:0]  core_nonce_q, prev_q;
    logic [NCORES-1:0]        cv_q, pv_q, samp_q;
    logic                     push;
    logic [31:0]              push_dat;
    logic                     unused_init;

    assign unused_init = ^initnonce[31:BW];
    assign base_sum    = {1'b0, base_q} + (BW+1)'(NCORES);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        gap_d     = gap_q;
        base_d    = base_q;
        wrapped_d = wrapped_q;
        load      = 1'b0;
        if (shift) begin
            state_d = ST_HOLD;
            phase_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    state_d   = ST_GAP;
                    gap_d     = 1'b0;
                    load      = 1'b1;
                    base_d    = initnonce[BW-1:0];
                    wrapped_d = 1'b0;
                end
                ST_GAP: begin
                    if (gap_q) state_d = ST_RUN;
                    else       gap_d   = 1'b1;
                end
                ST_RUN: begin
                    if (phase_q == PW'(PERIOD-1)) begin
                        phase_d = '0;
                        base_d  = base_sum[BW-1:0];
                        if (base_sum[BW]) wrapped_d = 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            gap_q       <= 1'b0;
            base_q      <= '0;
            wrapped_q   <= 1'b0;
            nonce_out_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            gap_q       <= gap_d;
            base_q      <= base_d;
            wrapped_q   <= wrapped_d;
            nonce_out_q <= {nonce_msb, base_d};
        end
    end

    for (genvar g = 0; g < NCORES; g++) begin : g_start
        assign core_start[g] = !shift && (state_q == ST_RUN) && (phase_q == PW'(g));
    end

    // pv_q marks that prev_q holds a nonce this core actually hashed since the last load.
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            core_nonce_q <= '0;
            prev_q       <= '0;
            cv_q         <= '0;
            pv_q         <= '0;
            samp_q       <= '0;
        end else begin
            samp_q <= core_start;
            if (shift) begin
                cv_q <= '0;
                pv_q <= '0;
            end
            for (int c = 0; c < NCORES; c++) begin
                if (core_start[c]) begin
                    core_nonce_q[c] <= {nonce_msb, base_q + BW'(c)};
                    prev_q[c]       <= core_nonce_q[c];
                    pv_q[c]         <= cv_q[c];
                    cv_q[c]         <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        push     = 1'b0;
        push_dat = '0;
        for (int c = 0; c < NCORES; c++) begin
            if (samp_q[c] && core_match[c] && pv_q[c] && !shift) begin
                push     = 1'b1;
                push_dat = prev_q[c];
            end
        end
    end

    gn_fifo #(
        .DEPTH (GN_DEPTH),
        .W     (32)
    ) u_gn_fifo (
        .clk_i      (hash_clk),
        .rst_ni     (rst_n),
        .push_i     (push),
        .push_dat_i (push_dat),
        .ovf_clr_i  (load),
        .rdy_i      (gn_ready),
        .vld_o      (gn_valid),
        .dat_o      (gn_nonce),
        .ovf_o      (gn_overflow)
    );

    assign core_nonce = core_nonce_q;
    assign gn_strobe  = push;
    assign wrapped    = wrapped_q;
    assign nonce_out  = nonce_out_q;

endmodule

// File: tb/tb_hashcore_mc.sv
// Self-checking bench: schedule-based reference model of starts, nonces, matches and the golden FIFO.
module tb_hashcore_mc;
    localparam int NC = 2;
    localparam int P  = 16;
    localparam int PX = 5;
    localparam int GD = 4;
    localparam int BW = 32 - PX;

    logic                hash_clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                shift = 1'b0;
    logic [31:0]         initnonce = '0;
    logic [PX-1:0]       nonce_msb = 5'h03;
    logic [NC-1:0]       core_start;
    logic [32*NC-1:0]    core_nonce;
    logic [NC-1:0]       core_match = '0;
    logic [31:0]         gn_nonce;
    logic                gn_valid;
    logic                gn_ready = 1'b0;
    logic                gn_strobe;
    logic                gn_overflow;
    logic                wrapped;
    logic [31:0]         nonce_out;

    int          total = 0;
    int          bad = 0;
    logic [31:0] q[$];
    logic        ovf_m = 1'b0;
    logic [31:0] cn_m [NC];

    hashcore_mc #(.NCORES(NC), .PERIOD(P), .PREFIX_W(PX), .GN_DEPTH(GD)) dut (
        .hash_clk    (hash_clk),
        .rst_n       (rst_n),
        .shift       (shift),
        .initnonce   (initnonce),
        .nonce_msb   (nonce_msb),
        .core_start  (core_start),
        .core_nonce  (core_nonce),
        .core_match  (core_match),
        .gn_nonce    (gn_nonce),
        .gn_valid    (gn_valid),
        .gn_ready    (gn_ready),
        .gn_strobe   (gn_strobe),
        .gn_overflow (gn_overflow),
        .wrapped     (wrapped),
        .nonce_out   (nonce_out)
    );

    always #5 hash_clk = ~hash_clk;

    // Load with init, then run ncyc cycles from the load cycle (k=0); the first start is due at k=3.
    // mmode: 0 none, 1 random, 2 all cores, 3 core 1 only. rmode: 0 never, 1 random, 2 always, 3 only on accept.
    task automatic run(input logic [31:0] init, input int ncyc, input int mmode, input int rmode, input int shift_at);
        longint      b0;
        longint      cur;
        int          n;
        bit          sh;
        bit          rdy;
        logic        acc;
        logic [31:0] accd;
        logic [NC-1:0] exp_start;
        b0 = longint'(init[BW-1:0]);
        n  = 0;
        shift = 1'b1; core_match = '0; gn_ready = 1'b0;
        repeat (2) begin
            @(negedge hash_clk);
            total++;
            if (core_start !== '0) begin bad++; $display("FAIL hold_start got=%b want=0", core_start); end
            @(posedge hash_clk); #1;
        end
        initnonce = init;
        for (int k = 0; k < ncyc; k++) begin
            sh = (shift_at >= 0) && (k >= shift_at);
            shift = sh;
            exp_start = '0;
            if (!sh && k >= 3 && (k-3) % P < NC) exp_start[(k-3) % P] = 1'b1;
            case (mmode)
                0:       core_match = '0;
                1:       core_match = NC'($urandom);
                2:       core_match = '1;
                default: core_match = NC'(2);
            endcase
            acc = 1'b0; accd = '0;
            if (!sh && k >= 4 && (k-4) % P < NC && (k-4) / P >= 1 && core_match[(k-4) % P]) begin
                acc  = 1'b1;
                accd = {nonce_msb, BW'(b0 + longint'((k-4) / P - 1) * NC + (k-4) % P)};
            end
            case (rmode)
                0:       rdy = 1'b0;
                1:       rdy = 1'($urandom % 2);
                2:       rdy = 1'b1;
                default: rdy = acc;
            endcase
            gn_ready = rdy;
            cur = b0 + longint'(n) * NC;
            @(negedge hash_clk);
            total++;
            if (core_start !== exp_start) begin bad++; $display("FAIL core_start k=%0d got=%b want=%b", k, core_start, exp_start); end
            total++;
            if (gn_strobe !== acc) begin bad++; $display("FAIL gn_strobe k=%0d got=%b want=%b", k, gn_strobe, acc); end
            total++;
            if (gn_valid !== (q.size() > 0)) begin bad++; $display("FAIL gn_valid k=%0d got=%b want=%b", k, gn_valid, q.size() > 0); end
            if (q.size() > 0) begin
                total++;
                if (gn_nonce !== q[0]) begin bad++; $display("FAIL gn_nonce k=%0d got=%h want=%h", k, gn_nonce, q[0]); end
            end
            total++;
            if (gn_overflow !== ovf_m) begin bad++; $display("FAIL gn_overflow k=%0d got=%b want=%b", k, gn_overflow, ovf_m); end
            for (int c = 0; c < NC; c++) begin
                total++;
                if (core_nonce[32*c +: 32] !== cn_m[c]) begin
                    bad++; $display("FAIL core_nonce%0d k=%0d got=%h want=%h", c, k, core_nonce[32*c +: 32], cn_m[c]);
                end
            end
            if (k >= 1) begin
                total++;
                if (wrapped !== (cur >= (64'd1 << BW))) begin bad++; $display("FAIL wrapped k=%0d got=%b want=%b", k, wrapped, cur >= (64'd1 << BW)); end
                total++;
                if (nonce_out !== {nonce_msb, BW'(cur)}) begin bad++; $display("FAIL nonce_out k=%0d got=%h want=%h", k, nonce_out, {nonce_msb, BW'(cur)}); end
            end
            for (int c = 0; c < NC; c++)
                if (exp_start[c]) cn_m[c] = {nonce_msb, BW'(b0 + longint'((k-3) / P) * NC + c)};
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (k == 0) ovf_m = 1'b0;
            if (acc) begin
                if (q.size() < GD) q.push_back(accd);
                else               ovf_m = 1'b1;
            end
            if (!sh && k >= 3 && (k-3) % P == P-1) n++;
            @(posedge hash_clk); #1;
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({core_start, core_nonce, gn_valid, gn_nonce, gn_strobe, gn_overflow, wrapped, nonce_out} !== '0) begin
            bad++; $display("FAIL reset_outputs got nonzero start=%b nonce_out=%h gn_valid=%b", core_start, nonce_out, gn_valid);
        end
        for (int c = 0; c < NC; c++) cn_m[c] = '0;
        @(posedge hash_clk); #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge hash_clk);
            total++;
            if (core_start !== '0 || gn_valid !== 1'b0) begin bad++; $display("FAIL idle_no_start got start=%b valid=%b want 0", core_start, gn_valid); end
            @(posedge hash_clk); #1;
        end
    endtask

    task automatic test_basic();
        run(32'h0000_0100, 3 + 3*P, 3, 0, -1);
        total++;
        if (gn_valid !== 1'b1 || gn_nonce !== 32'h1800_0101) begin
            bad++; $display("FAIL basic_first_golden got valid=%b nonce=%h want 1/18000101", gn_valid, gn_nonce);
        end
    endtask

    task automatic test_overflow();
        run(32'h0000_0000, 12, 0, 2, -1);
        run(32'h0000_0200, 3 + 4*P, 2, 0, -1);
        total++;
        if (gn_overflow !== 1'b1 || gn_nonce !== 32'h1800_0200) begin
            bad++; $display("FAIL overflow_set got ovf=%b head=%h want 1/18000200", gn_overflow, gn_nonce);
        end
        run(32'h0000_0300, 10, 0, 0, -1);
        run(32'h0000_0400, 40, 2, 3, -1);
        total++;
        if (gn_overflow !== 1'b0) begin bad++; $display("FAIL push_pop_full got ovf=%b want 0", gn_overflow); end
        run(32'h0000_0500, 10, 0, 2, -1);
    endtask

    task automatic test_wrap();
        run(32'h07FF_FFFE, 3 + P + 3, 0, 2, -1);
        total++;
        if (wrapped !== 1'b1 || nonce_out !== 32'h1800_0000) begin
            bad++; $display("FAIL wrap got wrapped=%b nonce_out=%h want 1/18000000", wrapped, nonce_out);
        end
        run(32'h0000_0000, 4, 0, 2, -1);
        total++;
        if (wrapped !== 1'b0) begin bad++; $display("FAIL wrap_clear got %b want 0", wrapped); end
    endtask

    task automatic test_shift_mid();
        run(32'h0000_0600, 3 + 2*P + 8, 2, 0, 3 + 2*P + 1);
        run(32'h0000_0700, 3 + P + 4, 0, 2, -1);
    endtask

    task automatic test_random();
        int ncyc;
        int sa;
        for (int i = 0; i < 4; i++) begin
            nonce_msb = PX'($urandom);
            ncyc = int'($urandom_range(80, 20));
            sa = ($urandom % 2 == 1) ? -1 : int'($urandom_range(ncyc, 4));
            run($urandom, ncyc, 1, 1, sa);
        end
        nonce_msb = 5'h03;
    endtask

    task automatic test_async_reset();
        run(32'h0000_0800, 30, 1, 0, -1);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({core_start, core_nonce, gn_valid, gn_nonce, gn_strobe, gn_overflow, wrapped, nonce_out} !== '0) begin
            bad++; $display("FAIL async_reset got start=%b valid=%b nonce_out=%h want 0", core_start, gn_valid, nonce_out);
        end
        q.delete();
        ovf_m = 1'b0;
        for (int c = 0; c < NC; c++) cn_m[c] = '0;
        @(posedge hash_clk); #3;
        rst_n = 1'b1;
        @(posedge hash_clk); #1;
        repeat (40) begin
            @(negedge hash_clk);
            total++;
            if (core_start !== '0) begin bad++; $display("FAIL post_reset_start got=%b want=0", core_start); end
            @(posedge hash_clk); #1;
        end
        run(32'h0000_0900, 3 + 2*P, 2, 1, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_wrap();
        test_shift_mid();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hashcore_mc.md
HASHCORE_MC -- requirements
Module: hashcore_mc

Interface
REQ-001 Parameter NCORES, default 2, number of hash cores served (1..PERIOD).
REQ-002 Parameter PERIOD, default 16, clocks per hash round (>=2).
REQ-003 Parameter PREFIX_W, default 5, hardwired nonce MSB width (1..8).
REQ-004 Parameter GN_DEPTH, default 4, golden-nonce FIFO depth (power of 2, >=2).
REQ-005 hash_clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 shift  in  1  work load in progress; cores held while high.
REQ-008 initnonce  in  32  start nonce, valid on the shift falling edge.
REQ-009 nonce_msb  in  PREFIX_W  per-chip nonce prefix, quasi-static.
REQ-010 core_start  out  NCORES  one-cycle start strobe per core.
REQ-011 core_nonce  out  32*NCORES  nonce per core; core c in bits [32c+31:32c].
REQ-012 core_match  in  NCORES  per-core golden match flag.
REQ-013 gn_nonce  out  32  FIFO head; valid when gn_valid=1.
REQ-014 gn_valid / gn_ready  out / in  1 each  FIFO pop handshake.
REQ-015 gn_strobe  out  1  one-cycle pulse per accepted match.
REQ-016 gn_overflow  out  1  sticky, a match was dropped.
REQ-017 wrapped  out  1  sticky, nonce counter wrapped since last load.
REQ-018 nonce_out  out  32  current round base {nonce_msb, base}.

Function
REQ-019 Counter base, width 32-PREFIX_W; phase counter 0..PERIOD-1.
REQ-020 Phase c (c<NCORES): core_start[c]=1 for one cycle; core_nonce[c] <= {nonce_msb, base+c} (mod 2^(32-PREFIX_W)) in that same cycle; prev_nonce[c] <= old core_nonce[c].
REQ-021 Phase PERIOD-1: base <= base+NCORES; phase wraps to 0.
REQ-022 Carry out of base sets wrapped; counting continues modulo; wrapped cleared only on load or reset.
REQ-023 core_match[c] sampled only in the cycle after core c's start; match refers to prev_nonce[c]; ignored if core c has not yet completed a round since load (per-core valid bit).
REQ-024 Staggered starts give at most one FIFO push per cycle.
REQ-025 Accepted match: push prev_nonce[c]; gn_strobe=1 same cycle as the push.
REQ-026 Pop when gn_valid & gn_ready; push and pop in one cycle always allowed, including when full.
REQ-027 Push when full and no pop: entry dropped, gn_overflow <= 1; cleared on load or reset.
REQ-028 shift high: no starts; phase held at 0; per-core valid bits cleared; sampled matches discarded; FIFO retained.
REQ-029 Shift falling edge (load): base <= initnonce[31-PREFIX_W:0]; wrapped and gn_overflow cleared; 2 idle cycles, then phase 0.
REQ-030 States: IDLE (after reset, before first load), HOLD (shift high), GAP (2 idle cycles), RUN; transitions IDLE/RUN/GAP->HOLD on shift=1, HOLD->GAP on falling edge, GAP->RUN after 2 cycles.

Reset
REQ-031 rst_n=0 immediately zeroes all registers and outputs: core_start, core_nonce, gn_*, wrapped, nonce_out, FIFO pointers; state IDLE.
REQ-032 Reset release mid-round restarts in IDLE; a load is required before any start.

Structure
REQ-033 Shared package hashcore_pkg holds state enum and default parameter constants.
REQ-034 One sub-module gn_fifo (parametrised GN_DEPTH x 32, valid/ready pop, full/overflow).

Verification
REQ-035 NCORES=2, PERIOD=16, nonce_msb=5'h03, load initnonce 0x00000100 -> starts at RUN phases 0,1 with nonces 0x18000100, 0x18000101; next round 0x18000102, 0x18000103.
REQ-036 core_match[1]=1 the cycle after core 1's second start -> gn_strobe pulse, gn_valid=1, gn_nonce=0x18000101; core_match during first round -> ignored.
REQ-037 Load initnonce 0x07FFFFFE -> after one round base=0, nonce_out=0x18000000, wrapped=1; next load clears wrapped.
REQ-038 GN_DEPTH=4, gn_ready=0, 5 valid matches -> 4 stored, gn_overflow=1, pops return matches 1..4 in order; push+pop when full -> no overflow.
REQ-039 shift raised at phase 1 of RUN -> no further core_start, matches ignored, FIFO contents kept; falling edge -> phase 0 start exactly 2 cycles later.
REQ-040 rst_n asserted mid-RUN -> all outputs 0 without a clock edge; no start until a new load.
